// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I encodings and load/store unit types: funct3
//               load/store constants, LSU state encoding, byte-enable
//               patterns and access-size decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    // Load funct3 encodings
    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    // LSU state machine encoding
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t LSU_IDLE = 2'd0;
    localparam lsu_state_t LSU_REQ  = 2'd1;
    localparam lsu_state_t LSU_WAIT = 2'd2;
    localparam lsu_state_t LSU_RESP = 2'd3;

    // Byte-enable patterns before lane shifting
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Access size encoding
    typedef logic [1:0] lsu_size_t;
    localparam lsu_size_t SIZE_B = 2'd0;
    localparam lsu_size_t SIZE_H = 2'd1;
    localparam lsu_size_t SIZE_W = 2'd2;

    // Access size implied by funct3; anything not byte/half is handled as a word
    function automatic lsu_size_t lsu_size(input logic [2:0] f3);
        case (f3)
            FUNCT3_B, FUNCT3_BU: lsu_size = SIZE_B;
            FUNCT3_H, FUNCT3_HU: lsu_size = SIZE_H;
            default:             lsu_size = SIZE_W;
        endcase
    endfunction

    // Encodings with no defined load or store meaning
    function automatic logic lsu_reserved(input logic we, input logic [2:0] f3);
        if (we) begin
            lsu_reserved = (f3 > FUNCT3_SW);
        end else begin
            lsu_reserved = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_lsu_load_align.sv
// ============================================================================
// Module      : riscv_lsu_load_align
// Description : Combinational load-data aligner. Selects the addressed byte
//               or halfword from a memory word and sign/zero-extends it
//               according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension of the returned word
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_rdata;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Only a[1] picks the halfword; a[0] is ignored for halves
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            FUNCT3_B:  o_data = {{24{w_byte[7]}}, w_byte};
            FUNCT3_BU: o_data = {24'h000000, w_byte};
            FUNCT3_H:  o_data = {{16{w_half[15]}}, w_half};
            FUNCT3_HU: o_data = {16'h0000, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_lsu.sv
// ============================================================================
// Module      : riscv_lsu
// Description : RV32I load/store unit. Accepts one decoded load/store at a
//               time, drives a word-wide req/gnt/rvalid data memory port and
//               returns an aligned, extended load result (or error) as a
//               single-cycle response pulse. A response that does not arrive
//               within TIMEOUT_CYC cycles of the grant becomes a bus error.
//               Optional build macro RISCV_LSU_MISALIGN_TRAP_EN: misaligned
//               half/word accesses return an error without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_funct3;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_reserved;
    logic              w_misalign;
    lsu_size_t         w_size;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_data;
    logic [31:0]       w_rsp_data;

    assign w_accept   = req_valid && (r_state == LSU_IDLE);
    assign w_reserved = lsu_reserved(req_we, req_funct3);
    assign w_size     = w_reserved ? SIZE_W : lsu_size(req_funct3);

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SIZE_H) && req_addr[0]) ||
                        ((w_size == SIZE_W) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        w_be    = BE_WORD;
        w_wdata = req_wdata;
        case (w_size)
            SIZE_B: begin
                w_be    = BE_BYTE << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                w_be    = BE_HALF << {req_addr[1], 1'b0};
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = BE_WORD;
                w_wdata = req_wdata;
            end
        endcase
        if (!req_we) begin
            w_wdata = 32'h0000_0000;
        end
    end

    riscv_lsu_load_align u_load_align (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    // Stores complete with zero data; loads return the extended lane
    assign w_rsp_data = r_mem_we ? 32'h0000_0000 : w_load_data;

    // Transaction state machine, request capture and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LSU_IDLE;
            r_cnt       <= '0;
            r_addr_lo   <= 2'b00;
            r_funct3    <= 3'b000;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_addr_lo   <= req_addr[1:0];
                        r_funct3    <= req_funct3;
                        r_mem_we    <= req_we;
                        r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        if (w_reserved || w_misalign) begin
                            // Error responses never reach the memory port
                            r_rsp_rdata <= 32'h0000_0000;
                            r_rsp_err   <= 1'b1;
                            r_state     <= LSU_RESP;
                        end else begin
                            r_state <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_gnt) begin
                        if (mem_rvalid) begin
                            r_rsp_rdata <= w_rsp_data;
                            r_rsp_err   <= 1'b0;
                            r_state     <= LSU_RESP;
                        end else begin
                            // The grant cycle counts as the first waited cycle
                            r_cnt   <= CNT_W'(1);
                            r_state <= LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mem_rvalid) begin
                        // Data beats a coincident timeout
                        r_rsp_rdata <= w_rsp_data;
                        r_rsp_err   <= 1'b0;
                        r_state     <= LSU_RESP;
                    end else if (r_cnt == c_cnt_last) begin
                        r_rsp_rdata <= 32'h0000_0000;
                        r_rsp_err   <= 1'b1;
                        r_state     <= LSU_RESP;
                    end
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == LSU_IDLE);
    assign mem_req   = (r_state == LSU_REQ);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = (r_state == LSU_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu.sv
// ============================================================================
// Module      : tb_riscv_lsu
// Description : Self-checking bench for riscv_lsu. Table of load/store
//               vectors with a scripted memory responder and a response
//               scoreboard, plus a hand-written reset-during-WAIT sequence.
//               Honours RISCV_LSU_MISALIGN_TRAP_EN for misaligned vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_lsu;

    localparam int TO = 4;
    localparam int NV = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    riscv_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;       // REQ cycles before gnt
        int          rv;      // WAIT cycle index of rvalid, -1 = with gnt
        bit          no_rv;   // never answer (timeout)
        bit          acc;     // memory access expected
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] erdata;
        bit          eerr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    vec_t vecs[NV];
    rsp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int g, input int rv,
                                input bit norv, input bit acc, input logic [31:0] ma,
                                input logic [3:0] be, input logic [31:0] mwd,
                                input logic [31:0] er, input bit ee);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.g = g; v.rv = rv; v.no_rv = norv; v.acc = acc; v.maddr = ma; v.be = be;
        v.mwdata = mwd; v.erdata = er; v.eerr = ee;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        rsp_t e;
        int   q;
        int   cg;
        bit   gnt_done;
        bit   done;
        bit   saw_req;
        chk({v.name, " ready_before"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.rdata = v.erdata;
        e.err   = v.eerr;
        if (!v.acc)        e.lat = 1;
        else if (v.no_rv)  e.lat = 1 + v.g + TO;
        else if (v.rv < 0) e.lat = 2 + v.g;
        else               e.lat = 3 + v.g + v.rv;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        q = 0; cg = -1; gnt_done = 0; done = 0; saw_req = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            chk({v.name, " ready_busy"}, {31'd0, req_ready}, 32'd0);
            if (rsp_valid) begin
                done = 1;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL %s unexpected_rsp: got rsp_valid=1 required none", v.name);
                end else begin
                    e = sb.pop_front();
                    chk({v.name, " rsp_rdata"}, rsp_rdata, e.rdata);
                    chk({v.name, " rsp_err"}, {31'd0, rsp_err}, {31'd0, e.err});
                    chk({v.name, " latency"}, c, e.lat);
                end
            end else if (mem_req) begin
                saw_req = 1;
                chk({v.name, " mem_addr"}, mem_addr, v.maddr);
                chk({v.name, " mem_be"}, {28'd0, mem_be}, {28'd0, v.be});
                chk({v.name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
                if (v.we) chk({v.name, " mem_wdata"}, mem_wdata, v.mwdata);
                if (!gnt_done && q == v.g) begin
                    mem_gnt  = 1'b1;
                    gnt_done = 1;
                    cg       = c;
                    if (v.rv < 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.rdata;
                    end
                end
                q++;
            end else if (gnt_done && !v.no_rv && v.rv >= 0 && (c - cg - 1) == v.rv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s rsp_timeout: got no rsp_valid required one pulse", v.name);
            sb.delete();
        end
        chk({v.name, " mem_access"}, {31'd0, saw_req}, {31'd0, v.acc});
        @(posedge clk); #1;
        chk({v.name, " single_pulse"}, {31'd0, rsp_valid}, 32'd0);
        chk({v.name, " ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
    endtask

    initial begin
        bit found;
        vecs[0]  = mk("lb_103", 0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 0, 0, 1, 32'h100, 4'b1000, 0, 32'hFFFF_FF80, 0);
        vecs[1]  = mk("lhu_102", 0, 3'b101, 32'h102, 0, 32'h8001_0000, 0, 0, 0, 1, 32'h100, 4'b1100, 0, 32'h0000_8001, 0);
        vecs[2]  = mk("lw_100", 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'h100, 4'b1111, 0, 32'hDEAD_BEEF, 0);
        vecs[3]  = mk("sb_201", 1, 3'b000, 32'h201, 32'h0000_00A5, 0, 0, 0, 0, 1, 32'h200, 4'b0010, 32'hA5A5_A5A5, 0, 0);
        vecs[4]  = mk("sh_202", 1, 3'b001, 32'h202, 32'h1234_C0DE, 0, 0, 0, 0, 1, 32'h200, 4'b1100, 32'hC0DE_C0DE, 0, 0);
        vecs[5]  = mk("sw_204", 1, 3'b010, 32'h204, 32'h1234_5678, 0, 1, 1, 0, 1, 32'h204, 4'b1111, 32'h1234_5678, 0, 0);
        vecs[6]  = mk("lh_100", 0, 3'b001, 32'h100, 0, 32'h0000_8123, 0, 0, 0, 1, 32'h100, 4'b0011, 0, 32'hFFFF_8123, 0);
        vecs[7]  = mk("lbu_101", 0, 3'b100, 32'h101, 0, 32'h0000_F500, 0, 0, 0, 1, 32'h100, 4'b0010, 0, 32'h0000_00F5, 0);
        vecs[8]  = mk("lb_102", 0, 3'b000, 32'h102, 0, 32'h007F_0000, 0, 0, 0, 1, 32'h100, 4'b0100, 0, 32'h0000_007F, 0);
        vecs[9]  = mk("lw_delayed", 0, 3'b010, 32'h300, 0, 32'hCAFE_F00D, 3, 2, 0, 1, 32'h300, 4'b1111, 0, 32'hCAFE_F00D, 0);
        vecs[10] = mk("lbu_gnt_rv", 0, 3'b100, 32'h302, 0, 32'h00AB_0000, 0, -1, 0, 1, 32'h300, 4'b0100, 0, 32'h0000_00AB, 0);
        vecs[11] = mk("lw_timeout", 0, 3'b010, 32'h400, 0, 0, 1, 0, 1, 1, 32'h400, 4'b1111, 0, 32'h0000_0000, 1);
        vecs[12] = mk("ld_rsvd", 0, 3'b011, 32'h500, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0, 0, 32'h0000_0000, 1);
        vecs[13] = mk("st_rsvd", 1, 3'b011, 32'h504, 32'h1111_2222, 0, 0, 0, 0, 0, 32'h0, 4'b0, 0, 32'h0000_0000, 1);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        vecs[14] = mk("lw_101", 0, 3'b010, 32'h101, 0, 32'h1122_3344, 0, 0, 0, 0, 32'h0, 4'b0, 0, 32'h0000_0000, 1);
        vecs[15] = mk("lh_103", 0, 3'b001, 32'h103, 0, 32'hFEDC_0000, 0, 0, 0, 0, 32'h0, 4'b0, 0, 32'h0000_0000, 1);
`else
        vecs[14] = mk("lw_101", 0, 3'b010, 32'h101, 0, 32'h1122_3344, 0, 0, 0, 1, 32'h100, 4'b1111, 0, 32'h1122_3344, 0);
        vecs[15] = mk("lh_103", 0, 3'b001, 32'h103, 0, 32'hFEDC_0000, 0, 0, 0, 1, 32'h100, 4'b1100, 0, 32'hFFFF_FEDC, 0);
`endif
        vecs[16] = mk("lw_rv_at_expiry", 0, 3'b010, 32'h600, 0, 32'h0BAD_CAFE, 0, TO - 2, 0, 1, 32'h600, 4'b1111, 0, 32'h0BAD_CAFE, 0);

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while waiting for a store ack: outputs clear at once, late ack ignored
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h700; req_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (mem_req) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rstwait mem_req_seen", {31'd0, found}, 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("rstwait mem_we_before", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("rst_in_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rstwait no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("rstwait idle_after", {31'd0, req_ready}, 32'd1);
            @(posedge clk); #1;
        end
        run_vec(vecs[2]);

        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
